fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode-stage
//  control unit and feeds it Instr_D (opcode/fun/target fields) and PC_plus4_D.
//  Owns the PC, the next-PC selection (sequential / jump from decode / taken branch from execute),
//  a variable-latency instruction-memory handshake, and a one-entry hold buffer for stalls.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'hC000_0000  bubble word (Rtype, fun=and, rd=$0) driven on Instr_D when Valid_D=0
// PORTS
//  clk              in   1   clock, all state updates on rising edge
//  rst              in   1   synchronous, active-high reset
//  imem_req         out  1   fetch request to instruction memory
//  imem_addr        out  32  fetch address; stable while imem_req=1 and imem_ack=0
//  imem_ack         in   1   request complete, imem_rdata valid this cycle (same-cycle ack allowed)
//  imem_rdata       in   32  fetched instruction word
//  Stall_F          in   1   hazard unit: hold PC and IF/ID register
//  Jump_D           in   1   control unit: instruction in Instr_D is a jump
//  Branch_taken_E   in   1   execute stage: branch resolved taken
//  Branch_target_E  in   32  execute stage: branch target address
//  PC_F             out  32  current fetch PC
//  Instr_D          out  32  IF/ID instruction to decode
//  PC_plus4_D       out  32  IF/ID PC+4 of Instr_D
//  Valid_D          out  1   Instr_D holds a real instruction (0 = bubble)
// BEHAVIOUR
//  - Reset: PC_F=RESET_PC, Instr_D=NOP_INSTR, PC_plus4_D=0, Valid_D=0, state=RUN, hold buffer empty;
//    imem_req=0 in any cycle rst=1. Abandoned in-flight requests must be tolerated by memory.
//  - States: RUN (imem_req=1, addr=PC_F), HOLD (imem_req=0, fetched word buffered),
//    DRAIN (imem_req=1, addr unchanged, awaiting ack of a stale request).
//  - Redirect priority per cycle: Branch_taken_E > (Jump_D & Valid_D) > sequential.
//    Jump target = {PC_plus4_D[31:28], Instr_D[25:0], 2'b00}. Redirect overrides Stall_F.
//  - RUN, ack, no redirect, !Stall_F: Instr_D<=imem_rdata, PC_plus4_D<=PC_F+4, Valid_D<=1,
//    PC_F<=PC_F+4. Latency: word visible on Instr_D the cycle after ack.
//  - RUN, ack, no redirect, Stall_F: buffer word and PC_F+4 in hold regs, D regs unchanged, -> HOLD.
//  - RUN, no ack, no redirect: PC_F held; if !Stall_F, D <= bubble (Valid_D=0, Instr_D=NOP_INSTR).
//  - HOLD: D and PC_F held while Stall_F=1; on Stall_F=0 transfer hold regs to D (Valid_D=1),
//    PC_F<=PC_F+4, -> RUN. Buffered word delivered exactly once.
//  - Redirect (any state): D <= bubble regardless of Stall_F.
//    RUN with ack same cycle: discard rdata, PC_F<=target, stay RUN.
//    RUN without ack: latch target in redirect_pc, -> DRAIN (imem_addr must not change).
//    HOLD: discard hold buffer, PC_F<=target, -> RUN.
//    DRAIN: Branch_taken_E overwrites redirect_pc (Jump_D ignored since Valid_D=0).
//  - DRAIN, ack: discard rdata, PC_F<=redirect_pc, -> RUN (new request next cycle).
//  - Arithmetic: PC+4 modulo 2^32 (32'hFFFF_FFFC -> 0). Targets used as given, no alignment check.
// TESTING
//  1. Reset, imem_ack=1 always, rdata=addr^32'hA5A5_0000 -> Instr_D words for 0,4,8; PC_plus4_D=4,8,12; Valid_D=1 from cycle 2.
//  2. ack every 3rd cycle -> imem_addr stable across waits; two bubbles (Valid_D=0, NOP_INSTR) between words.
//  3. Stall_F=1 for 4 cycles spanning an ack of 0x10 -> HOLD, imem_req=0; 0x10 word appears once after release.
//  4. Request 0x20 pending, Branch_taken_E target 0x100, ack 2 cycles later -> 0x20 data dropped, next imem_addr=0x100.
//  5. Instr_D target 26'h40, PC_plus4_D=0x1000_0010, Jump_D=1 -> next fetch 0x1000_0100; with Branch_taken_E to 0x200 same cycle -> 0x200.
//  6. PC_F=0xFFFF_FFFC ack -> PC_F=0; rst asserted in DRAIN -> imem_req=0 that cycle, next fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, variable-latency imem handshake,
// a one-entry hold buffer for stalls and a drain state for abandoned in-flight fetches.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'hC000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        Stall_F,
   input  logic        Jump_D,
   input  logic        Branch_taken_E,
   input  logic [31:0] Branch_target_E,
   output logic [31:0] PC_F,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_plus4_D,
   output logic        Valid_D
);

   typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc_next;
   logic [31:0] instr_next;
   logic [31:0] pc4_next;
   logic        valid_next;
   logic [31:0] hold_instr;
   logic [31:0] hold_instr_next;
   logic [31:0] hold_pc4;
   logic [31:0] hold_pc4_next;
   logic [31:0] redirect_pc;
   logic [31:0] redirect_pc_next;

   logic        jump_taken;
   logic        redirect;
   logic [31:0] jump_target;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   assign pc_plus4    = PC_F + 32'd4;
   assign jump_taken  = Jump_D & Valid_D;
   assign redirect    = Branch_taken_E | jump_taken;
   assign jump_target = {PC_plus4_D[31:28], Instr_D[25:0], 2'b00};
   assign target      = Branch_taken_E ? Branch_target_E : jump_target;

   // PC_F is never updated while a request is pending, so it doubles as the stable fetch address.
   assign imem_req  = ~rst & (state != HOLD);
   assign imem_addr = PC_F;

   always_comb begin
      state_next       = state;
      pc_next          = PC_F;
      instr_next       = Instr_D;
      pc4_next         = PC_plus4_D;
      valid_next       = Valid_D;
      hold_instr_next  = hold_instr;
      hold_pc4_next    = hold_pc4;
      redirect_pc_next = redirect_pc;
      case (state)
         RUN: begin
            if (redirect) begin
               instr_next = NOP_INSTR;
               valid_next = 1'b0;
               if (imem_ack) begin
                  pc_next = target;
               end else begin
                  redirect_pc_next = target;
                  state_next       = DRAIN;
               end
            end else if (imem_ack) begin
               if (Stall_F) begin
                  hold_instr_next = imem_rdata;
                  hold_pc4_next   = pc_plus4;
                  state_next      = HOLD;
               end else begin
                  instr_next = imem_rdata;
                  pc4_next   = pc_plus4;
                  valid_next = 1'b1;
                  pc_next    = pc_plus4;
               end
            end else if (!Stall_F) begin
               instr_next = NOP_INSTR;
               valid_next = 1'b0;
            end
         end
         HOLD: begin
            if (redirect) begin
               instr_next = NOP_INSTR;
               valid_next = 1'b0;
               pc_next    = target;
               state_next = RUN;
            end else if (!Stall_F) begin
               instr_next = hold_instr;
               pc4_next   = hold_pc4;
               valid_next = 1'b1;
               pc_next    = pc_plus4;
               state_next = RUN;
            end
         end
         DRAIN: begin
            // Decode only ever sees bubbles here, so a jump cannot be active; a late branch wins.
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
            if (Branch_taken_E) redirect_pc_next = Branch_target_E;
            if (imem_ack) begin
               pc_next    = Branch_taken_E ? Branch_target_E : redirect_pc;
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         PC_F        <= RESET_PC;
         Instr_D     <= NOP_INSTR;
         PC_plus4_D  <= 32'd0;
         Valid_D     <= 1'b0;
         hold_instr  <= 32'd0;
         hold_pc4    <= 32'd0;
         redirect_pc <= 32'd0;
      end else begin
         state       <= state_next;
         PC_F        <= pc_next;
         Instr_D     <= instr_next;
         PC_plus4_D  <= pc4_next;
         Valid_D     <= valid_next;
         hold_instr  <= hold_instr_next;
         hold_pc4    <= hold_pc4_next;
         redirect_pc <= redirect_pc_next;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based reference model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'hC000_0000;

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc4;
   } hold_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        Stall_F;
   logic        Jump_D;
   logic        Branch_taken_E;
   logic [31:0] Branch_target_E;
   logic [31:0] PC_F;
   logic [31:0] Instr_D;
   logic [31:0] PC_plus4_D;
   logic        Valid_D;

   logic        ack_en;
   logic        check_en = 1'b0;
   int          compared = 0;
   int          mismatched = 0;

   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_valid;
   logic        m_stale;
   logic [31:0] m_redir;
   hold_t       hold_q[$];

   fetch_stage dut (
      .clk(clk),
      .rst(rst),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .Stall_F(Stall_F),
      .Jump_D(Jump_D),
      .Branch_taken_E(Branch_taken_E),
      .Branch_target_E(Branch_target_E),
      .PC_F(PC_F),
      .Instr_D(Instr_D),
      .PC_plus4_D(PC_plus4_D),
      .Valid_D(Valid_D)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      if (addr == 32'h1000_000C) return 32'h0800_0040;
      return addr ^ 32'hA5A5_0000;
   endfunction

   // Memory only answers live requests.
   assign imem_ack   = ack_en & imem_req;
   assign imem_rdata = mem_word(imem_addr);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference: the fetch stream is a sequence of addresses; a redirect either lands at once
   // or waits for the abandoned fetch to return; stalled words wait in a queue.
   task automatic modelStep();
      logic        ack;
      logic        redirect;
      logic [31:0] tgt;
      hold_t       e;
      if (rst) begin
         m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
         m_stale = 1'b0; m_redir = 32'h0; hold_q.delete();
         return;
      end
      ack      = ack_en && (hold_q.size() == 0);
      redirect = Branch_taken_E || (Jump_D && m_valid);
      tgt      = Branch_taken_E ? Branch_target_E : {m_pc4[31:28], m_instr[25:0], 2'b00};
      if (m_stale) begin
         m_instr = NOP; m_valid = 1'b0;
         if (Branch_taken_E) m_redir = Branch_target_E;
         if (ack) begin
            m_pc = m_redir; m_stale = 1'b0;
         end
      end else if (redirect) begin
         m_instr = NOP; m_valid = 1'b0;
         if (ack || hold_q.size() != 0) m_pc = tgt;
         else begin
            m_redir = tgt; m_stale = 1'b1;
         end
         hold_q.delete();
      end else if (hold_q.size() != 0) begin
         if (!Stall_F) begin
            e = hold_q.pop_front();
            m_instr = e.word; m_pc4 = e.pc4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
         end
      end else if (ack) begin
         e.word = mem_word(m_pc);
         e.pc4  = m_pc + 32'd4;
         if (Stall_F) hold_q.push_back(e);
         else begin
            m_instr = e.word; m_pc4 = e.pc4; m_valid = 1'b1; m_pc = e.pc4;
         end
      end else if (!Stall_F) begin
         m_instr = NOP; m_valid = 1'b0;
      end
   endtask

   task automatic applyStimulus(input logic r, input logic a, input logic s, input logic j,
                                input logic b, input logic [31:0] bt);
      rst = r; ack_en = a; Stall_F = s; Jump_D = j; Branch_taken_E = b; Branch_target_E = bt;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (check_en) begin
            logic exp_req;
            exp_req = !rst && (hold_q.size() == 0);
            checkOutput("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            if (exp_req) checkOutput("imem_addr", imem_addr, m_pc);
            checkOutput("PC_F", PC_F, m_pc);
            checkOutput("Instr_D", Instr_D, m_instr);
            checkOutput("PC_plus4_D", PC_plus4_D, m_pc4);
            checkOutput("Valid_D", {31'b0, Valid_D}, {31'b0, m_valid});
         end
      end
   end

   initial begin
      applyStimulus(1, 0, 0, 0, 0, 32'h0);
      applyStimulus(1, 0, 0, 0, 0, 32'h0);
      check_en = 1'b1;
      checkOutput("reset PC_F", PC_F, 32'h0);
      checkOutput("reset Instr_D", Instr_D, NOP);
      checkOutput("reset PC_plus4_D", PC_plus4_D, 32'h0);
      checkOutput("reset Valid_D", {31'b0, Valid_D}, 32'h0);
      checkOutput("reset imem_req", {31'b0, imem_req}, 32'h0);

      // Back-to-back acks
      applyStimulus(0, 1, 0, 0, 0, 32'h0);
      checkOutput("t1 Instr_D@0", Instr_D, 32'hA5A5_0000);
      checkOutput("t1 PC_plus4_D@0", PC_plus4_D, 32'h4);
      applyStimulus(0, 1, 0, 0, 0, 32'h0);
      checkOutput("t1 Instr_D@4", Instr_D, 32'hA5A5_0004);
      applyStimulus(0, 1, 0, 0, 0, 32'h0);
      checkOutput("t1 Instr_D@8", Instr_D, 32'hA5A5_0008);
      checkOutput("t1 PC_plus4_D@8", PC_plus4_D, 32'hC);

      // Ack every third cycle
      applyStimulus(0, 0, 0, 0, 0, 32'h0);
      checkOutput("t2 bubble", Instr_D, NOP);
      applyStimulus(0, 0, 0, 0, 0, 32'h0);
      checkOutput("t2 addr stable", imem_addr, 32'hC);
      applyStimulus(0, 1, 0, 0, 0, 32'h0);
      checkOutput("t2 Instr_D@C", Instr_D, 32'hA5A5_000C);

      // Stall across an ack of 0x10
      applyStimulus(0, 1, 1, 0, 0, 32'h0);
      checkOutput("t3 hold no req", {31'b0, imem_req}, 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0, 32'h0);
      checkOutput("t3 D held", Instr_D, 32'hA5A5_000C);
      applyStimulus(0, 0, 0, 0, 0, 32'h0);
      checkOutput("t3 Instr_D@10", Instr_D, 32'hA5A5_0010);
      checkOutput("t3 PC_F", PC_F, 32'h14);
      applyStimulus(0, 0, 0, 0, 0, 32'h0);
      checkOutput("t3 once only", {31'b0, Valid_D}, 32'h0);

      // Branch while 0x20 is in flight
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 32'h0);
      applyStimulus(0, 0, 0, 0, 1, 32'h100);
      checkOutput("t4 drain addr", imem_addr, 32'h20);
      applyStimulus(0, 0, 0, 0, 0, 32'h0);
      applyStimulus(0, 1, 0, 0, 0, 32'h0);
      checkOutput("t4 redirect addr", imem_addr, 32'h100);
      checkOutput("t4 dropped", Instr_D, NOP);
      applyStimulus(0, 1, 0, 0, 0, 32'h0);
      checkOutput("t4 Instr_D@100", Instr_D, 32'hA5A5_0100);

      // Jump from decode, then jump with simultaneous branch
      applyStimulus(0, 1, 0, 0, 1, 32'h1000_000C);
      applyStimulus(0, 1, 0, 0, 0, 32'h0);
      checkOutput("t5 jump word", Instr_D, 32'h0800_0040);
      checkOutput("t5 jump pc4", PC_plus4_D, 32'h1000_0010);
      applyStimulus(0, 1, 0, 1, 0, 32'h0);
      checkOutput("t5 jump target", PC_F, 32'h1000_0100);
      applyStimulus(0, 1, 0, 0, 1, 32'h1000_000C);
      applyStimulus(0, 1, 0, 0, 0, 32'h0);
      applyStimulus(0, 1, 0, 1, 1, 32'h200);
      checkOutput("t5 branch wins", PC_F, 32'h200);

      // PC wrap, then reset during drain
      applyStimulus(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
      applyStimulus(0, 1, 0, 0, 0, 32'h0);
      checkOutput("t6 wrap PC_F", PC_F, 32'h0);
      checkOutput("t6 wrap PC_plus4_D", PC_plus4_D, 32'h0);
      checkOutput("t6 wrap Instr_D", Instr_D, 32'h5A5A_FFFC);
      applyStimulus(0, 0, 0, 0, 1, 32'h300);
      applyStimulus(1, 0, 0, 0, 0, 32'h0);
      checkOutput("t6 rst no req", {31'b0, imem_req}, 32'h0);
      applyStimulus(0, 1, 0, 0, 0, 32'h0);
      checkOutput("t6 refetch Instr_D", Instr_D, 32'hA5A5_0000);
      checkOutput("t6 refetch PC_plus4_D", PC_plus4_D, 32'h4);

      @(negedge clk);
      #1;
      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
